// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg
// Shared constants for the ALU result stage:
//   - op codes that steer the 5:1 result mux (ADD, SUB, XOR, SLT, NAND/NOR),
//   - bit positions of the five status flags stored with every entry,
//   - a helper that packs the individual flags into the 5-bit flag vector.
package alu_result_stage_pkg;

    typedef enum logic [3:0] {
        CTL_ADD      = 4'd0,
        CTL_SUB      = 4'd1,
        CTL_XOR      = 4'd2,
        CTL_SLT      = 4'd3,
        CTL_NAND_NOR = 4'd4
    } alu_ctl_e;

    // Highest legal op code; anything above it is an illegal op.
    localparam int unsigned CTL_LAST   = 4;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_NEG   = 1;
    localparam int unsigned FLAG_CARRY = 2;
    localparam int unsigned FLAG_OVF   = 3;
    localparam int unsigned FLAG_ILL   = 4;
    localparam int unsigned FLAG_W     = 5;

    // Place each flag at its fixed index so every user agrees on the layout.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic ill,
        input logic ovf,
        input logic carry,
        input logic neg,
        input logic zero
    );
        logic [FLAG_W-1:0] f;
        f             = {FLAG_W{1'b0}};
        f[FLAG_ILL]   = ill;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen
// Combinational flag generator applied to each ALU result before it is
// stored in the result stage.
// Ports:
//   in_result   [WIDTH-1:0]  raw mux output
//   in_ctl      [CTLW-1:0]   op code that steered the mux
//   in_carryout              adder carryout
//   in_overflow              adder overflow
//   san_result  [WIDTH-1:0]  sanitised result (0 for illegal op codes)
//   san_flags   [4:0]        {illegal, overflow, carry, negative, zero}
module alu_flag_gen
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTLW  = 4
) (
    input  logic [WIDTH-1:0]  in_result,
    input  logic [CTLW-1:0]   in_ctl,
    input  logic              in_carryout,
    input  logic              in_overflow,
    output logic [WIDTH-1:0]  san_result,
    output logic [FLAG_W-1:0] san_flags
);

    logic             illegal_s;
    logic             adder_op_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             ovf_s;

    // Classify the op code and sanitise the result; carry/overflow only
    // mean something when the adder produced the result.
    always_comb begin
        illegal_s  = 1'b0;
        adder_op_s = 1'b0;
        result_s   = in_result;
        carry_s    = 1'b0;
        ovf_s      = 1'b0;
        if (in_ctl > CTLW'(CTL_LAST)) begin
            illegal_s = 1'b1;
            result_s  = {WIDTH{1'b0}};
        end else begin
            illegal_s  = 1'b0;
            adder_op_s = (in_ctl == CTLW'(CTL_ADD)) || (in_ctl == CTLW'(CTL_SUB));
            result_s   = in_result;
        end
        if (adder_op_s) begin
            carry_s = in_carryout;
            ovf_s   = in_overflow;
        end else begin
            carry_s = 1'b0;
            ovf_s   = 1'b0;
        end
    end

    // SLT gets no special negative handling: the sign bit is taken as-is.
    always_comb begin
        san_result = result_s;
        san_flags  = pack_flags(illegal_s, ovf_s, carry_s,
                                result_s[WIDTH-1],
                                (result_s == {WIDTH{1'b0}}));
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the 32-bit 5:1 ALU result mux. Each accepted
// result is sanitised, tagged with status flags and held in an in-order
// buffer of DEPTH entries behind a valid/ready handshake, so the ALU can keep
// issuing while register-file writeback stalls.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        upstream handshake (in_ready = count != DEPTH)
//   in_result, in_ctl          mux output and its op code
//   in_carryout, in_overflow   adder status for the result
//   out_valid / out_ready      downstream handshake (out_valid = count != 0)
//   out_result, out_ctl        head entry (zero while out_valid is low)
//   out_flags                  {illegal, overflow, carry, negative, zero}
//   occupancy                  number of held entries
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CTLW  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [CTLW-1:0]          in_ctl,
    input  logic                     in_carryout,
    input  logic                     in_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [CTLW-1:0]          out_ctl,
    output logic [4:0]               out_flags,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [WIDTH-1:0]  mem_result_r [DEPTH];
    logic [CTLW-1:0]   mem_ctl_r    [DEPTH];
    logic [FLAG_W-1:0] mem_flags_r  [DEPTH];

    logic [PTRW-1:0]   wr_ptr_r;
    logic [PTRW-1:0]   rd_ptr_r;
    logic [CNTW-1:0]   count_r;

    logic [WIDTH-1:0]  san_result_s;
    logic [FLAG_W-1:0] san_flags_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;

    alu_flag_gen #(
        .WIDTH (WIDTH),
        .CTLW  (CTLW)
    ) u_flag_gen (
        .in_result   (in_result),
        .in_ctl      (in_ctl),
        .in_carryout (in_carryout),
        .in_overflow (in_overflow),
        .san_result  (san_result_s),
        .san_flags   (san_flags_s)
    );

    // Handshake decode; ready depends only on the count, never on out_ready,
    // so a full stage refuses a push even when a pop happens on that edge.
    always_comb begin
        full_s  = (count_r == CNTW'(DEPTH));
        empty_s = (count_r == CNTW'(0));
        push_s  = in_valid && !full_s;
        pop_s   = !empty_s && out_ready;
    end

    // Buffer storage, pointers and entry count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {CNTW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_result_r[i] <= {WIDTH{1'b0}};
                mem_ctl_r[i]    <= {CTLW{1'b0}};
                mem_flags_r[i]  <= {FLAG_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_result_r[wr_ptr_r] <= san_result_s;
                mem_ctl_r[wr_ptr_r]    <= in_ctl;
                mem_flags_r[wr_ptr_r]  <= san_flags_s;
                wr_ptr_r <= (wr_ptr_r == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}}
                                                           : wr_ptr_r + PTRW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTRW'(DEPTH - 1)) ? {PTRW{1'b0}}
                                                           : rd_ptr_r + PTRW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the head entry; outputs are forced to zero while empty so the
    // stale storage contents never leak downstream.
    always_comb begin
        in_ready  = !full_s;
        out_valid = !empty_s;
        occupancy = count_r;
        if (!empty_s) begin
            out_result = mem_result_r[rd_ptr_r];
            out_ctl    = mem_ctl_r[rd_ptr_r];
            out_flags  = mem_flags_r[rd_ptr_r];
        end else begin
            out_result = {WIDTH{1'b0}};
            out_ctl    = {CTLW{1'b0}};
            out_flags  = {FLAG_W{1'b0}};
        end
    end

endmodule
